pow2_scheduler: RTL

POW2_SCHEDULER -- requirements
Module: pow2_scheduler

---
 rtl/pow2_scheduler_pkg.sv | 19 +
 rtl/stage3_pow2_approx.sv | 65 ++++++
 rtl/pow2_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/pow2_scheduler_pkg.sv
// Shared constants and types for the two-requester pow2 scheduler.
// Q6.10 fixed-point format plus default pipeline and accumulator sizing.
package pow2_scheduler_pkg;

    localparam int unsigned QWidth = 16;
    localparam int unsigned QFrac = 10;
    localparam logic [QWidth-1:0] QOne = 16'h0400;

    localparam int unsigned PipeLatDefault = 1;
    localparam int unsigned AccWDefault = 22;
    localparam int unsigned NumReq = 2;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

endpackage

// File: rtl/stage3_pow2_approx.sv
// Piecewise-linear 2^x in Q6.10: 2^floor(x) * (1 + frac(x)), saturating at 0x7FFF.
// PIPE_LAT register stages carry the result and the operand bypass.
module stage3_pow2_approx
    import pow2_scheduler_pkg::*;
#(
    parameter int unsigned PIPE_LAT = PipeLatDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid_in,
    input  logic [QWidth-1:0] in_x,
    output logic              valid_out,
    output logic [QWidth-1:0] out_x,
    output logic [QWidth-1:0] out_pow
);

    logic signed [5:0]  ipart;
    logic        [5:0]  rshift;
    logic [QWidth-1:0]  mant;
    logic [QWidth-1:0]  pow_d;

    logic              valid_q [PIPE_LAT];
    logic [QWidth-1:0] x_q     [PIPE_LAT];
    logic [QWidth-1:0] pow_q   [PIPE_LAT];

    always_comb begin
        ipart  = in_x[15:10];
        rshift = -ipart;
        mant   = {5'b0, 1'b1, in_x[9:0]};
        pow_d  = '0;
        // Integer part of 5 or more overflows the signed Q6.10 range.
        if (ipart > 6'sd4) begin
            pow_d = 16'h7FFF;
        end else if (ipart >= 6'sd0) begin
            pow_d = mant << ipart[2:0];
        end else begin
            pow_d = mant >> rshift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                valid_q[i] <= 1'b0;
                x_q[i]     <= '0;
                pow_q[i]   <= '0;
            end
        end else if (en) begin
            valid_q[0] <= valid_in;
            x_q[0]     <= in_x;
            pow_q[0]   <= pow_d;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                x_q[i]     <= x_q[i-1];
                pow_q[i]   <= pow_q[i-1];
            end
        end
    end

    assign valid_out = valid_q[PIPE_LAT-1];
    assign out_x     = x_q[PIPE_LAT-1];
    assign out_pow   = pow_q[PIPE_LAT-1];

endmodule

// File: rtl/pow2_scheduler.sv
// Round-robin time-sharing of one pow2 unit between two requesters, with
// per-requester saturating vector-sum accumulators and sum-done pulses.
module pow2_scheduler
    import pow2_scheduler_pkg::*;
#(
    parameter int unsigned PIPE_LAT = PipeLatDefault,
    parameter int unsigned ACC_W    = AccWDefault
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NumReq-1:0]             req_valid,
    input  logic [NumReq-1:0][QWidth-1:0] req_x,
    input  logic [NumReq-1:0]             req_last,
    output logic [NumReq-1:0]             req_ready,
    output logic                          rsp_valid,
    output logic                          rsp_id,
    output logic [QWidth-1:0]             rsp_x,
    output logic [QWidth-1:0]             rsp_pow,
    output logic [NumReq-1:0]             sum_valid,
    output logic [ACC_W-1:0]              sum_out
);

    localparam int unsigned SumW = ((ACC_W > QWidth) ? ACC_W : QWidth) + 1;
    localparam logic [ACC_W-1:0] AccMax = '1;

    logic              rr_q;
    tag_t              tag_q [PIPE_LAT];
    logic [ACC_W-1:0]  acc_q [NumReq];
    logic [NumReq-1:0] sum_valid_q;
    logic [ACC_W-1:0]  sum_out_q;

    logic [NumReq-1:0] grant;
    logic [QWidth-1:0] issue_x;
    logic              pow_valid;
    tag_t              tail;
    logic [SumW-1:0]   sum_wide;
    logic [ACC_W-1:0]  acc_sat;

    always_comb begin
        grant = '0;
        if (en) begin
            grant[0] = req_valid[0] & (~req_valid[1] | (rr_q == 1'b0));
            grant[1] = req_valid[1] & (~req_valid[0] | (rr_q == 1'b1));
        end
        issue_x = grant[1] ? req_x[1] : req_x[0];
    end

    assign req_ready = grant;

    stage3_pow2_approx #(
        .PIPE_LAT (PIPE_LAT)
    ) u_pow2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (|grant),
        .in_x      (issue_x),
        .valid_out (pow_valid),
        .out_x     (rsp_x),
        .out_pow   (rsp_pow)
    );

    assign tail      = tag_q[PIPE_LAT-1];
    assign rsp_valid = tail.valid & pow_valid;
    assign rsp_id    = tail.id;

    always_comb begin
        sum_wide = SumW'(acc_q[rsp_id]) + SumW'(rsp_pow);
        acc_sat  = (sum_wide > SumW'(AccMax)) ? AccMax : ACC_W'(sum_wide);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = 0; i < NumReq; i++) begin
                acc_q[i] <= '0;
            end
            sum_valid_q <= '0;
            sum_out_q   <= '0;
        end else if (en) begin
            if (|grant) begin
                rr_q <= grant[0];
            end
            tag_q[0] <= '{valid: |grant, id: grant[1],
                          last: grant[1] ? req_last[1] : req_last[0]};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            sum_valid_q <= '0;
            // The final term is folded into the reported sum, then the vector restarts.
            if (rsp_valid) begin
                if (tail.last) begin
                    acc_q[rsp_id]       <= '0;
                    sum_out_q           <= acc_sat;
                    sum_valid_q[rsp_id] <= 1'b1;
                end else begin
                    acc_q[rsp_id] <= acc_sat;
                end
            end
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_out   = sum_out_q;

endmodule
